// File: rtl/semiauto_pkg.sv
// Encodings shared by the semi-auto next-state logic and its motion register.
package semiauto_pkg;

    typedef enum logic [1:0] {
        FWD  = 2'b00,
        WAIT = 2'b01,
        TURN = 2'b10,
        COOL = 2'b11
    } state_t;

    typedef enum logic [3:0] {
        STOP         = 4'b0000,
        MOVE_FORWARD = 4'b0001,
        TURN_LEFT    = 4'b0100,
        TURN_RIGHT   = 4'b1000
    } motion_t;

    // 20 ms at 100 MHz
    localparam int unsigned DEFAULT_TICK_DIV = 2000000;

    function automatic logic is_turn_motion(input logic [3:0] m);
        return (m == TURN_LEFT) || (m == TURN_RIGHT);
    endfunction

endpackage

// File: rtl/semiauto_motion_reg_tick_prescaler.sv
// Free-running divider: tick is high for the cycle in which the count wraps.
module tick_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/semiauto_motion_reg.sv
// Registered state/motion stage after the semi-auto next-state logic, with turn timing.
// Define SEMIAUTO_RELEASE_LOCK_EN to enable the button-release lockout after a turn.
module semiauto_motion_reg
    import semiauto_pkg::*;
#(
    parameter int unsigned TICK_DIV     = DEFAULT_TICK_DIV,
    parameter int unsigned TURN_TICKS   = 45,
    parameter int unsigned AROUND_TICKS = 90,
    parameter int unsigned CNT_W        = 11
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       power,
    input  logic [1:0] global_state,
    input  logic [1:0] next_state,
    input  logic [3:0] next_moving_state,
    input  logic       left,
    input  logic       right,
    input  logic       straight,
    input  logic       back,
    output logic [1:0] state,
    output logic [3:0] moving_state,
    output logic       turn_done,
    output logic       busy
);

`ifdef SEMIAUTO_RELEASE_LOCK_EN
    localparam logic LOCK_EN = 1'b1;
`else
    localparam logic LOCK_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_TICKS - 1);
    localparam logic [CNT_W-1:0] AROUND_LAST = CNT_W'(AROUND_TICKS - 1);

    state_t           state_q, state_d;
    logic [3:0]       mov_q, mov_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             around_q, around_d;
    logic             lock_q, lock_d;
    logic             done_q, done_d;
    logic             busy_q;

    logic active;
    logic any_button;
    logic tick;
    logic [CNT_W-1:0] last;

    assign active     = power && ((global_state == 2'b01) || (global_state == 2'b10));
    assign any_button = left || right || straight || back;
    assign last       = around_q ? AROUND_LAST : TURN_LAST;

    // Prescaler is held clear outside TURN, so it restarts at 0 on every entry.
    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (sys_clk),
        .clr  (rst || !active || (state_q != TURN)),
        .en   (state_q == TURN),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        mov_d    = mov_q;
        cnt_d    = cnt_q;
        around_d = around_q;
        lock_d   = lock_q;
        done_d   = 1'b0;

        if (!active) begin
            state_d  = WAIT;
            mov_d    = STOP;
            cnt_d    = '0;
            around_d = 1'b0;
            lock_d   = 1'b0;
        end else if (state_q == TURN) begin
            if (tick) begin
                if (cnt_q == last) begin
                    state_d = WAIT;
                    mov_d   = STOP;
                    done_d  = 1'b1;
                    lock_d  = LOCK_EN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else begin
            if (lock_q && !any_button) begin
                lock_d = 1'b0;
            end
            // The override still holds in the release cycle itself.
            if (lock_q && (next_state != WAIT)) begin
                state_d = WAIT;
                mov_d   = STOP;
            end else if (next_state == TURN) begin
                if (is_turn_motion(next_moving_state)) begin
                    state_d  = TURN;
                    mov_d    = next_moving_state;
                    cnt_d    = '0;
                    around_d = (next_moving_state == TURN_RIGHT) && back;
                end else begin
                    state_d = WAIT;
                    mov_d   = STOP;
                end
            end else begin
                state_d = state_t'(next_state);
                mov_d   = next_moving_state;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q  <= WAIT;
            mov_q    <= STOP;
            cnt_q    <= '0;
            around_q <= 1'b0;
            lock_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mov_q    <= mov_d;
            cnt_q    <= cnt_d;
            around_q <= around_d;
            lock_q   <= lock_d;
            done_q   <= done_d;
            busy_q   <= (state_d == TURN);
        end
    end

    assign state        = state_q;
    assign moving_state = mov_q;
    assign turn_done    = done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_semiauto_motion_reg.sv
// Scoreboard bench for semiauto_motion_reg with TICK_DIV=4, TURN_TICKS=3, AROUND_TICKS=6.
module tb_semiauto_motion_reg;

    logic       clk;
    logic       rst;
    logic       power;
    logic [1:0] global_state;
    logic [1:0] next_state;
    logic [3:0] next_moving_state;
    logic       left, right, straight, back;
    logic [1:0] state;
    logic [3:0] moving_state;
    logic       turn_done;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;

    int         q_cyc[$];
    logic [7:0] q_exp[$];
    string      q_name[$];

    semiauto_motion_reg #(
        .TICK_DIV     (4),
        .TURN_TICKS   (3),
        .AROUND_TICKS (6),
        .CNT_W        (11)
    ) dut (
        .sys_clk           (clk),
        .rst               (rst),
        .power             (power),
        .global_state      (global_state),
        .next_state        (next_state),
        .next_moving_state (next_moving_state),
        .left              (left),
        .right             (right),
        .straight          (straight),
        .back              (back),
        .state             (state),
        .moving_state      (moving_state),
        .turn_done         (turn_done),
        .busy              (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs after the edge 'ahead' edges from now.
    task automatic expect_at(input int ahead, input logic [1:0] st, input logic [3:0] mv,
                             input logic b, input logic d, input string name);
        q_cyc.push_back(cyc + ahead);
        q_exp.push_back({st, mv, b, d});
        q_name.push_back(name);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] got;
        logic [7:0] exp;
        string      nm;
        got = {state, moving_state, busy, turn_done};
        if (turn_done === 1'b1) done_cnt++;
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            exp = q_exp.pop_front();
            nm  = q_name.pop_front();
            checks++;
            if (q_cyc.pop_front() != cyc) begin
                failures++;
                $display("FAIL %s missed its cycle (now %0d)", nm, cyc);
            end else if (got !== exp) begin
                failures++;
                $display("FAIL %s cyc=%0d got st=%b mv=%b busy=%b done=%b exp st=%b mv=%b busy=%b done=%b",
                         nm, cyc, got[7:6], got[5:2], got[1], got[0],
                         exp[7:6], exp[5:2], exp[1], exp[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; power = 1'b1; global_state = 2'b01;
        next_state = 2'b01; next_moving_state = 4'b0000;
        left = 1'b0; right = 1'b0; straight = 1'b0; back = 1'b0;

        expect_at(1, 2'b01, 4'b0000, 1'b0, 1'b0, "reset_first_edge");
        step(1);
        expect_at(1, 2'b01, 4'b0000, 1'b0, 1'b0, "reset_second_edge");
        step(1);
        rst = 1'b0;

        // Pass-through and inactive mode
        next_state = 2'b00; next_moving_state = 4'b0001;
        expect_at(1, 2'b00, 4'b0001, 1'b0, 1'b0, "fwd_pass");
        step(1);
        next_state = 2'b11; next_moving_state = 4'b0000; global_state = 2'b10;
        expect_at(1, 2'b11, 4'b0000, 1'b0, 1'b0, "cool_pass");
        step(1);
        next_state = 2'b00; next_moving_state = 4'b0001; global_state = 2'b00;
        expect_at(1, 2'b01, 4'b0000, 1'b0, 1'b0, "mode_inactive");
        step(1);
        global_state = 2'b01; next_state = 2'b01; next_moving_state = 4'b0000;
        step(1);

        // Left turn: 3 ticks x 4 cycles
        next_state = 2'b10; next_moving_state = 4'b0100;
        expect_at(1,  2'b10, 4'b0100, 1'b1, 1'b0, "left_entry");
        expect_at(12, 2'b10, 4'b0100, 1'b1, 1'b0, "left_hold_last");
        expect_at(13, 2'b01, 4'b0000, 1'b0, 1'b1, "left_done");
        expect_at(14, 2'b01, 4'b0000, 1'b0, 1'b0, "left_done_pulse");
        step(1);
        next_state = 2'b01; next_moving_state = 4'b0000;
        step(15);

        // U-turn: 6 ticks x 4 cycles
        next_state = 2'b10; next_moving_state = 4'b1000; back = 1'b1;
        expect_at(1,  2'b10, 4'b1000, 1'b1, 1'b0, "uturn_entry");
        expect_at(13, 2'b10, 4'b1000, 1'b1, 1'b0, "uturn_past_90");
        expect_at(24, 2'b10, 4'b1000, 1'b1, 1'b0, "uturn_hold_last");
        expect_at(25, 2'b01, 4'b0000, 1'b0, 1'b1, "uturn_done");
        expect_at(26, 2'b01, 4'b0000, 1'b0, 1'b0, "uturn_done_pulse");
        step(1);
        next_state = 2'b01; next_moving_state = 4'b0000; back = 1'b0;
        step(27);

        // Right button held through completion
        next_state = 2'b10; next_moving_state = 4'b1000; right = 1'b1;
        expect_at(1,  2'b10, 4'b1000, 1'b1, 1'b0, "held_entry");
        expect_at(13, 2'b01, 4'b0000, 1'b0, 1'b1, "held_done");
`ifdef SEMIAUTO_RELEASE_LOCK_EN
        expect_at(14, 2'b01, 4'b0000, 1'b0, 1'b0, "lock_override");
        expect_at(16, 2'b01, 4'b0000, 1'b0, 1'b0, "lock_still_held");
        step(16);
        right = 1'b0;
        expect_at(1, 2'b01, 4'b0000, 1'b0, 1'b0, "lock_release_cycle");
        step(1);
        right = 1'b1;
        expect_at(1,  2'b10, 4'b1000, 1'b1, 1'b0, "lock_reentry");
        expect_at(13, 2'b01, 4'b0000, 1'b0, 1'b1, "lock_reentry_done");
        step(1);
        next_state = 2'b01; next_moving_state = 4'b0000; right = 1'b0;
        step(14);
`else
        expect_at(14, 2'b10, 4'b1000, 1'b1, 1'b0, "retrigger");
        expect_at(26, 2'b01, 4'b0000, 1'b0, 1'b1, "retrigger_done");
        step(14);
        next_state = 2'b01; next_moving_state = 4'b0000; right = 1'b0;
        step(14);
`endif

        // Abort mid-turn via power
        next_state = 2'b10; next_moving_state = 4'b0100;
        expect_at(1, 2'b10, 4'b0100, 1'b1, 1'b0, "abort_entry");
        step(1);
        next_state = 2'b01; next_moving_state = 4'b0000;
        step(4);
        power = 1'b0;
        expect_at(1, 2'b01, 4'b0000, 1'b0, 1'b0, "abort_power_off");
        step(1);
        power = 1'b1;
        expect_at(1, 2'b01, 4'b0000, 1'b0, 1'b0, "abort_wait_held");
        expect_at(7, 2'b01, 4'b0000, 1'b0, 1'b0, "abort_no_done");
        step(10);

        // Illegal motion code on TURN request
        next_state = 2'b10; next_moving_state = 4'b0001;
        expect_at(1, 2'b01, 4'b0000, 1'b0, 1'b0, "illegal_entry");
        step(1);
        next_state = 2'b01; next_moving_state = 4'b0000;
        expect_at(1, 2'b01, 4'b0000, 1'b0, 1'b0, "illegal_after");
        step(3);

        checks++;
        if (done_cnt != 4) begin
            failures++;
            $display("FAIL done_pulse_count got=%0d exp=4", done_cnt);
        end
        checks++;
        if (q_cyc.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", q_cyc.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
